transmit_packet: RTL

- Downstream neighbour of the RX packet writer in the SFP loopback test path.
- Once a received packet sits in the shared 1024x32 packet RAM, this block reads it back through an Avalon-MM read master.
- It serialises the packet byte-wise onto the MAC TX Avalon-ST FIFO interface (ff_tx_*), framing it with sop/eop.
- It handles one packet at a time and accepts a descriptor (base word address plus byte length) via a valid/ready handshake.

---
 rtl/transmit_packet.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/transmit_packet.sv
// transmit_packet: reads one packet from the shared 1024x32 packet RAM through
// an Avalon-MM read master and streams it byte-wise (little-endian lanes) onto
// the MAC TX Avalon-ST FIFO interface, framed with sop/eop. One descriptor in
// flight at a time; no read-ahead, so each word costs 1 + READ_LATENCY + 4 cycles.
module transmit_packet #(
   parameter int READ_LATENCY = 2,
   parameter int LEN_W        = 12
) (
   input  logic             clk_original,
   input  logic             rst,
   input  logic             pkt_valid,
   output logic             pkt_ready,
   input  logic [9:0]       pkt_base,
   input  logic [LEN_W-1:0] pkt_len,
   output logic [9:0]       ram_addr,
   output logic             ram_chipselect,
   output logic             ram_read,
   input  logic [31:0]      ram_readdata,
   output logic [3:0]       ram_byteenable,
   output logic [7:0]       ff_tx_data,
   output logic             ff_tx_sop,
   output logic             ff_tx_eop,
   output logic             ff_tx_wren,
   input  logic             ff_tx_rdy,
   output logic             ff_tx_err,
   output logic             ff_tx_crc_fwd,
   output logic             tx_busy,
   output logic             tx_done,
   output logic [15:0]      tx_pkt_count
);

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, SEND} state_t;

   localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

   state_t           r_state;
   state_t           w_next;
   logic [9:0]       r_addr;
   logic [LEN_W-1:0] r_rem;
   logic [31:0]      r_word;
   logic [1:0]       r_lane;
   logic [2:0]       r_lanes;
   logic [1:0]       r_lat;
   logic             r_first;
   logic             r_busy;
   logic             r_done;
   logic [15:0]      r_count;

   logic             w_accept;
   logic             w_xfer;
   logic             w_last_lane;
   logic             w_last_byte;
   logic [2:0]       w_lanes;

   // Zero-length descriptors are consumed in IDLE but never start a transfer.
   assign w_accept    = pkt_valid && (r_state == IDLE) && (pkt_len != '0);
   assign w_xfer      = (r_state == SEND) && ff_tx_rdy;
   assign w_last_byte = (r_rem == LEN_W'(1));
   assign w_last_lane = ({1'b0, r_lane} == (r_lanes - 3'd1));
   assign w_lanes     = (r_rem >= LEN_W'(4)) ? 3'd4 : r_rem[2:0];

   assign ram_byteenable = 4'hF;
   assign ff_tx_err      = 1'b0;
   assign ff_tx_crc_fwd  = 1'b0;
   assign tx_busy        = r_busy;
   assign tx_done        = r_done;
   assign tx_pkt_count   = r_count;

   // State register.
   always_ff @(posedge clk_original or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic and state-decoded Avalon-MM / Avalon-ST outputs.
   always_comb begin
      w_next         = r_state;
      pkt_ready      = 1'b0;
      ram_chipselect = 1'b0;
      ram_read       = 1'b0;
      ram_addr       = '0;
      ff_tx_wren     = 1'b0;
      ff_tx_data     = '0;
      ff_tx_sop      = 1'b0;
      ff_tx_eop      = 1'b0;
      case (r_state)
         IDLE: begin
            pkt_ready = 1'b1;
            if (w_accept) w_next = RD_REQ;
         end
         RD_REQ: begin
            ram_chipselect = 1'b1;
            ram_read       = 1'b1;
            ram_addr       = r_addr;
            w_next         = RD_WAIT;
         end
         RD_WAIT: begin
            if (r_lat == 2'd0) w_next = SEND;
         end
         SEND: begin
            ff_tx_wren = 1'b1;
            ff_tx_data = r_word[8*r_lane +: 8];
            ff_tx_sop  = r_first;
            ff_tx_eop  = w_last_byte;
            if (w_xfer && w_last_lane) w_next = w_last_byte ? IDLE : RD_REQ;
         end
         default: w_next = IDLE;
      endcase
   end

   // Descriptor latch, read-latency countdown, word capture and lane/byte bookkeeping.
   always_ff @(posedge clk_original or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_rem   <= '0;
         r_word  <= '0;
         r_lane  <= '0;
         r_lanes <= '0;
         r_lat   <= '0;
         r_first <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
      end else begin
         r_done <= w_xfer && w_last_byte;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr  <= pkt_base;
                  r_rem   <= pkt_len;
                  r_first <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            RD_REQ: begin
               r_lat <= LAT_INIT;
            end
            RD_WAIT: begin
               if (r_lat == 2'd0) begin
                  r_word  <= ram_readdata;
                  r_lanes <= w_lanes;
                  r_lane  <= '0;
               end else begin
                  r_lat <= r_lat - 2'd1;
               end
            end
            SEND: begin
               if (w_xfer) begin
                  r_rem   <= r_rem - LEN_W'(1);
                  r_first <= 1'b0;
                  r_lane  <= r_lane + 2'd1;
                  if (w_last_lane) begin
                     if (w_last_byte) begin
                        r_busy  <= 1'b0;
                        r_count <= r_count + 16'd1;
                     end else begin
                        // 10-bit arithmetic: word 1023 wraps to word 0.
                        r_addr <= r_addr + 10'd1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
